// File: rtl/ativiade5_onchip_mem_ctrl.sv
// On-chip RAM slave with byte enables, post-reset/on-demand zero sweep, optional per-byte parity (ONCHIP_MEM_PARITY_EN).
// Reads return READ_LATENCY enabled cycles after acceptance; waitrequest holds off transfers while not READY or clken low.
module ativiade5_onchip_mem_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH/8-1:0] byteenable,
    input  logic                    chipselect,
    input  logic                    read,
    input  logic                    write,
    input  logic [DATA_WIDTH-1:0]   writedata,
    input  logic                    clken,
    input  logic                    clear_req,
`ifdef ONCHIP_MEM_PARITY_EN
    input  logic                    par_inject,
    output logic                    parity_err,
`endif
    output logic [DATA_WIDTH-1:0]   readdata,
    output logic                    readdatavalid,
    output logic                    waitrequest,
    output logic                    clear_busy
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        RESET = 2'd0,
        CLEAR = 2'd1,
        READY = 2'd2
    } state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   clr_cnt_q;
    logic                    clear_busy_q;

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic [READ_LATENCY-1:0]                 pipe_vld_q;
    logic [READ_LATENCY-1:0][DATA_WIDTH-1:0] pipe_dat_q;

    logic acc;
    logic wr_acc;
    logic rd_acc;
    logic pipe_en;

    assign waitrequest = (state_q != READY) | ~clken;
    assign acc         = chipselect & (read | write) & ~waitrequest;
    assign wr_acc      = acc & write;
    assign rd_acc      = acc & read & ~write;
    // The sweep runs regardless of clken, so the read pipeline drains with it.
    assign pipe_en     = clken | (state_q == CLEAR);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= RESET;
            clr_cnt_q    <= '0;
            clear_busy_q <= 1'b0;
        end else begin
            case (state_q)
                RESET: begin
                    if (CLEAR_ON_RESET != 0) begin
                        state_q      <= CLEAR;
                        clear_busy_q <= 1'b1;
                    end else begin
                        state_q      <= READY;
                    end
                end
                CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + ADDR_WIDTH'(1);
                    if (&clr_cnt_q) begin
                        state_q      <= READY;
                        clear_busy_q <= 1'b0;
                    end
                end
                READY: begin
                    if (clear_req) begin
                        state_q      <= CLEAR;
                        clear_busy_q <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= RESET;
                    clear_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign clear_busy = clear_busy_q;

    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem_q[clr_cnt_q] <= '0;
        end else if (wr_acc) begin
            for (int b = 0; b < NB; b++) begin
                if (byteenable[b]) mem_q[address][8*b +: 8] <= writedata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_vld_q <= '0;
            pipe_dat_q <= '0;
        end else if (pipe_en) begin
            pipe_vld_q[0] <= rd_acc;
            if (rd_acc) pipe_dat_q[0] <= mem_q[address];
            // Later stages only load on a valid beat, so the output holds its last value.
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                if (pipe_vld_q[i-1]) pipe_dat_q[i] <= pipe_dat_q[i-1];
            end
        end
    end

    assign readdata      = pipe_dat_q[READ_LATENCY-1];
    assign readdatavalid = pipe_vld_q[READ_LATENCY-1];

`ifdef ONCHIP_MEM_PARITY_EN
    logic [NB-1:0]                   par_mem_q [DEPTH];
    logic [READ_LATENCY-1:0][NB-1:0] pipe_par_q;
    logic [NB-1:0]                   par_calc;

    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            par_mem_q[clr_cnt_q] <= '0;
        end else if (wr_acc) begin
            for (int b = 0; b < NB; b++) begin
                if (byteenable[b]) par_mem_q[address][b] <= (^writedata[8*b +: 8]) ^ par_inject;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_par_q <= '0;
        end else if (pipe_en) begin
            if (rd_acc) pipe_par_q[0] <= par_mem_q[address];
            for (int i = 1; i < READ_LATENCY; i++) begin
                if (pipe_vld_q[i-1]) pipe_par_q[i] <= pipe_par_q[i-1];
            end
        end
    end

    always_comb begin
        par_calc = '0;
        for (int b = 0; b < NB; b++) begin
            par_calc[b] = ^pipe_dat_q[READ_LATENCY-1][8*b +: 8];
        end
    end

    assign parity_err = readdatavalid & (|(par_calc ^ pipe_par_q[READ_LATENCY-1]));
`endif

endmodule

// File: tb/tb_ativiade5_onchip_mem_ctrl.sv
// Directed bench for ativiade5_onchip_mem_ctrl with default parameters.
module tb_ativiade5_onchip_mem_ctrl;

    localparam int DW  = 32;
    localparam int AW  = 10;
    localparam int LAT = 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW-1:0] address;
    logic [DW/8-1:0] byteenable;
    logic          chipselect;
    logic          read;
    logic          write;
    logic [DW-1:0] writedata;
    logic          clken;
    logic          clear_req;
    logic [DW-1:0] readdata;
    logic          readdatavalid;
    logic          waitrequest;
    logic          clear_busy;
`ifdef ONCHIP_MEM_PARITY_EN
    logic          par_inject;
    logic          parity_err;
    logic          last_perr;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ativiade5_onchip_mem_ctrl #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .READ_LATENCY   (LAT),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .address       (address),
        .byteenable    (byteenable),
        .chipselect    (chipselect),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .clken         (clken),
        .clear_req     (clear_req),
`ifdef ONCHIP_MEM_PARITY_EN
        .par_inject    (par_inject),
        .parity_err    (parity_err),
`endif
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .waitrequest   (waitrequest),
        .clear_busy    (clear_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
        address    = a;
        writedata  = d;
        byteenable = be;
        chipselect = 1'b1;
        write      = 1'b1;
        @(negedge clk);
        chipselect = 1'b0;
        write      = 1'b0;
        byteenable = '0;
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
        int n = 1;
        address    = a;
        chipselect = 1'b1;
        read       = 1'b1;
        @(negedge clk);
        chipselect = 1'b0;
        read       = 1'b0;
        while (!readdatavalid && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'(LAT));
        chk({tag, "_dat"}, readdata, exp);
`ifdef ONCHIP_MEM_PARITY_EN
        last_perr = parity_err;
`endif
    endtask

    // Counts busy cycles of a sweep; optionally pulses clear_req at busy cycle req_at.
    task automatic measure_clear(input int req_at, output int cycles, output int viol);
        int w = 0;
        cycles = 0;
        viol   = 0;
        while (!clear_busy && w < 16) begin
            if (!waitrequest) viol++;
            @(negedge clk);
            w++;
        end
        while (clear_busy && cycles < 4000) begin
            if (!waitrequest) viol++;
            clear_req = (cycles == req_at);
            cycles++;
            @(negedge clk);
        end
        clear_req = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, viol, issued, got, last_c;

        reset_n    = 1'b0;
        address    = '0;
        byteenable = '0;
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        writedata  = '0;
        clken      = 1'b1;
        clear_req  = 1'b0;
`ifdef ONCHIP_MEM_PARITY_EN
        par_inject = 1'b0;
        last_perr  = 1'b0;
`endif

        // Reset state and post-reset sweep.
        repeat (2) @(negedge clk);
        chk("rst_vld",  32'(readdatavalid), 32'd0);
        chk("rst_dat",  readdata, 32'h0);
        chk("rst_wait", 32'(waitrequest), 32'd1);
        chk("rst_busy", 32'(clear_busy), 32'd0);
        reset_n = 1'b1;
        measure_clear(-1, cyc, viol);
        chk("init_sweep_len", 32'(cyc), 32'd1024);
        chk("init_sweep_wait", 32'(viol), 32'd0);
        rd(10'h3FF, 32'h0, "init_rd3ff");

        // Byte-enable writes, read-after-write, hold, no-op write, read+write.
        wr(10'h010, 32'hDEADBEEF, 4'b1111);
        wr(10'h010, 32'h11223344, 4'b0101);
        rd(10'h010, 32'hDE22BE44, "be_merge");
        @(negedge clk);
        chk("hold_vld", 32'(readdatavalid), 32'd0);
        chk("hold_dat", readdata, 32'hDE22BE44);
        wr(10'h010, 32'hFFFFFFFF, 4'b0000);
        rd(10'h010, 32'hDE22BE44, "be_none");
        address    = 10'h011;
        writedata  = 32'h5A5A5A5A;
        byteenable = 4'hF;
        chipselect = 1'b1;
        read       = 1'b1;
        write      = 1'b1;
        @(negedge clk);
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        chk("rw_novld", 32'(readdatavalid), 32'd0);
        rd(10'h011, 32'h5A5A5A5A, "rw_write");

        // Streaming reads with one clken=0 cycle.
        for (int i = 0; i < 8; i++) wr(10'(i), 32'hC0DE0000 + 32'(i), 4'hF);
        issued = 0;
        got    = 0;
        last_c = -1;
        for (int c = 0; c < 15; c++) begin
            clken = (c != 4);
            if (c == 4) begin
                #1;
                chk("stall_wait", 32'(waitrequest), 32'd1);
            end
            if (clken && readdatavalid) begin
                chk("stream_dat", readdata, 32'hC0DE0000 + 32'(got));
                got++;
                last_c = c;
            end
            if (issued < 8) begin
                address    = 10'(issued);
                chipselect = 1'b1;
                read       = 1'b1;
                if (clken) issued++;
            end else begin
                chipselect = 1'b0;
                read       = 1'b0;
            end
            @(negedge clk);
        end
        clken = 1'b1;
        chk("stream_cnt", 32'(got), 32'd8);
        chk("stream_last", 32'(last_c), 32'(8 + LAT));

        // clear_req with a read accepted the cycle before.
        wr(10'h200, 32'hA5A5A5A5, 4'hF);
        address    = 10'h200;
        chipselect = 1'b1;
        read       = 1'b1;
        @(negedge clk);
        chipselect = 1'b0;
        read       = 1'b0;
        clear_req  = 1'b1;
        chk("clr_prior_vld", 32'(readdatavalid), 32'd1);
        chk("clr_prior_dat", readdata, 32'hA5A5A5A5);
        @(negedge clk);
        clear_req = 1'b0;
        chk("clr_busy_on", 32'(clear_busy), 32'd1);
        measure_clear(100, cyc, viol);
        chk("clr_sweep_len", 32'(cyc), 32'd1024);
        chk("clr_sweep_wait", 32'(viol), 32'd0);
        rd(10'h200, 32'h0, "clr_rd200");
        rd(10'h010, 32'h0, "clr_rd010");

        // Reset asserted at sweep address 0x155.
        wr(10'h020, 32'h12345678, 4'hF);
        rd(10'h020, 32'h12345678, "pre_rst");
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        chk("mid_busy_on", 32'(clear_busy), 32'd1);
        repeat (10'h155) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(clear_busy), 32'd0);
        chk("mid_rst_wait", 32'(waitrequest), 32'd1);
        chk("mid_rst_vld",  32'(readdatavalid), 32'd0);
        chk("mid_rst_dat",  readdata, 32'h0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        measure_clear(-1, cyc, viol);
        chk("mid_sweep_len", 32'(cyc), 32'd1024);
        chk("mid_sweep_wait", 32'(viol), 32'd0);
        rd(10'h020, 32'h0, "mid_rd020");
        rd(10'h3FF, 32'h0, "mid_rd3ff");

`ifdef ONCHIP_MEM_PARITY_EN
        par_inject = 1'b1;
        wr(10'h005, 32'h000000FF, 4'hF);
        par_inject = 1'b0;
        rd(10'h005, 32'h000000FF, "par_bad");
        chk("par_err_set", 32'(last_perr), 32'd1);
        wr(10'h005, 32'h000000FF, 4'hF);
        rd(10'h005, 32'h000000FF, "par_good");
        chk("par_err_clr", 32'(last_perr), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
